sim_end_checker: RTL and testbench
==================================

# sim_end_checker

Synthesizable end-of-simulation monitor and result checker for the CPU/SRAM test harness. It snoops the data-memory write port, counts cycles, and detects the end-of-test store or a cycle timeout. It then takes over a data-memory read port to sweep the result window and compare each word against a golden ROM. Its pass/fail, error count and cycle count are usable on FPGA and in gate-level simulation, where hierarchical memory peeks are not available.

## Interface
- ADDR_W, 14, word-address width of data memory
- END_ADDR, 14'h3fff, word address of the end-of-test mailbox
- END_CODE, 32'hFFFF_FFFF, value that signals end of test
- TEST_START, 14'h2000, first word address of the result window
- CHECK_DEPTH, 1024, number of words compared (1..2^IDX_W)
- IDX_W, 16, golden index width
- MAX_CYCLES, 150000, timeout in cycles (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  4  DM byte write enables (snooped)
- wr_addr  in  ADDR_W  DM word address (snooped)
- wr_data  in  32  DM write data (snooped)
- chk_req  out  1  checker owns the DM read port; the wrapper stalls the CPU and muxes chk_addr
- chk_addr  out  ADDR_W  DM read address during the check sweep
- rd_data  in  32  DM read data, valid 1 cycle after chk_addr
- gold_idx  out  IDX_W  golden ROM index
- gold_data  in  32  golden word, valid 1 cycle after gold_idx
- mis_valid  out  1  1-cycle pulse per mismatch
- mis_idx  out  IDX_W  index of the mismatching word
- done  out  1  check sweep complete, held until reset
- pass  out  1  valid when done=1: err_cnt==0 and no timeout
- timeout  out  1  run ended by MAX_CYCLES
- err_cnt  out  16  mismatch count, saturating
- cycle_cnt  out  32  cycles spent in RUN

## Operation
- FSM: RUN → CHECK → DRAIN → DONE. Reset enters RUN.
- RUN:
  - cycle_cnt increments every cycle and saturates at 2^32−1.
  - End hit: wr_en==4'hF, wr_addr==END_ADDR and wr_data==END_CODE in the same cycle. On a hit, go to CHECK with timeout=0.
  - Partial-byte writes to END_ADDR, or any other value written there, are ignored.
  - If no hit occurs and cycle_cnt==MAX_CYCLES−1, set timeout=1 and go to CHECK.
  - If a hit and the timeout condition occur in the same cycle, the hit wins and timeout=0.
- CHECK:
  - chk_req=1.
  - Issue counter k runs 0..CHECK_DEPTH−1, one per cycle.
  - chk_addr=TEST_START+k, truncated to ADDR_W bits (wraps).
  - gold_idx=k.
  - After k=CHECK_DEPTH−1 is issued, go to DRAIN.
- Compare stage, one cycle behind issue:
  - If rd_data!==gold_data, assert mis_valid with mis_idx=k of that issue.
  - err_cnt increments and saturates at 16'hFFFF.
- DRAIN: chk_req=0. The final compare happens here. Go to DONE.
- DONE:
  - done=1 and pass=(err_cnt==0)&&!timeout.
  - All outputs are frozen. Snooped writes are ignored.
- cycle_cnt freezes on leaving RUN. Snooped writes are ignored outside RUN.

## Timing
- Reset values: chk_req=0, chk_addr=0, gold_idx=0, mis_valid=0, mis_idx=0, done=0, pass=0, timeout=0, err_cnt=0, cycle_cnt=0.
- All outputs are registered.
- Hit at RUN cycle n (cycle_cnt=n at that edge):
  - The final cycle_cnt is n+1.
  - chk_req rises on the next cycle.
  - chk_req stays high for exactly CHECK_DEPTH cycles.
  - done rises CHECK_DEPTH+2 cycles after chk_req rises.
- mis_valid is registered: it pulses 2 cycles after the corresponding issue.
- The err_cnt value is final when done rises.
- Asserting rst at any point, including mid-sweep, immediately clears all state and outputs. Operation restarts in RUN after rst deasserts.
- CHECK_DEPTH=1: one issue cycle, then DRAIN, then DONE.

## Test plan
- Clean pass:
  - Stimulus: CHECK_DEPTH=4; memory and ROM both hold {1,2,3,4}; full write of FFFF_FFFF to 3fff at cycle 100.
  - Required: chk_addr sequence 2000..2003; err_cnt=0; pass=1; timeout=0; cycle_cnt=101.
- Mismatch:
  - Stimulus: memory word 2 = 0xDEAD, golden = 3.
  - Required: single mis_valid pulse with mis_idx=2; err_cnt=1; pass=0.
- False end:
  - Stimulus: wr_en=4'h3 to 3fff with FFFF_FFFF; full write of 0 to 3fff; full write of FFFF_FFFF to 3ffe.
  - Required: all ignored; state stays RUN.
- Timeout:
  - Stimulus: MAX_CYCLES=50, no end store.
  - Required: timeout=1; cycle_cnt=50; the sweep still runs; pass=0 even when all words match.
- Same-cycle conflict:
  - Stimulus: end store issued at cycle_cnt=MAX_CYCLES−1.
  - Required: timeout=0; pass follows the comparison result.
- Reset mid-sweep:
  - Stimulus: rst pulse while k=2.
  - Required: all outputs return to reset values at once; a subsequent clean run passes.

Source files
------------

// File: rtl/sim_end_checker.sv
// sim_end_checker: end-of-test monitor and result checker for the CPU/SRAM harness.
// Snoops data-memory writes for the end-of-test mailbox store or a cycle timeout.
// It then takes over a data-memory read port and compares the result window
// against a golden ROM.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | CPU running; count cycles, watch for mailbox store / timeout
// ST_CHECK | own DM read port, issue one address/golden index per cycle
// ST_DRAIN | read port released; last issued word is compared here
// ST_DONE  | results published and frozen until reset
module sim_end_checker #(
  parameter int                ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] END_ADDR    = 14'h3fff,
  parameter logic [31:0]       END_CODE    = 32'hFFFF_FFFF,
  parameter logic [ADDR_W-1:0] TEST_START  = 14'h2000,
  parameter int                CHECK_DEPTH = 1024,
  parameter int                IDX_W       = 16,
  parameter int                MAX_CYCLES  = 150000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              chk_req,
  output logic [ADDR_W-1:0] chk_addr,
  input  logic [31:0]       rd_data,
  output logic [IDX_W-1:0]  gold_idx,
  input  logic [31:0]       gold_data,
  output logic              mis_valid,
  output logic [IDX_W-1:0]  mis_idx,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_CHECK, ST_DRAIN, ST_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(CHECK_DEPTH - 1);
  localparam logic [31:0]      LAST_CYC = 32'(MAX_CYCLES - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] k, k_nx;
  logic             end_hit;
  logic             cyc_limit;
  logic             cmp_vld;
  logic [IDX_W-1:0] cmp_idx;

  // Only a full-word store of the end code to the mailbox ends the run.
  assign end_hit   = (wr_en == 4'hF) && (wr_addr == END_ADDR) && (wr_data == END_CODE);
  assign cyc_limit = (cycle_cnt == LAST_CYC);

  // State register and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // Next-state logic; a mailbox hit and the timeout both leave RUN.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    case (state)
      ST_RUN: begin
        if (end_hit || cyc_limit) begin
          state_nx = ST_CHECK;
          k_nx     = '0;
        end
      end
      ST_CHECK: begin
        if (k == LAST_K) state_nx = ST_DRAIN;
        else             k_nx     = k + IDX_W'(1);
      end
      ST_DRAIN: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_RUN;
    endcase
  end

  // Registered outputs, cycle counter and the compare stage.
  // The compare runs one cycle behind issue because memory and ROM reads take
  // one cycle, so cmp_vld/cmp_idx are delayed copies of chk_req/gold_idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_req   <= 1'b0;
      chk_addr  <= '0;
      gold_idx  <= '0;
      mis_valid <= 1'b0;
      mis_idx   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      cycle_cnt <= '0;
      cmp_vld   <= 1'b0;
      cmp_idx   <= '0;
    end else begin
      mis_valid <= 1'b0;
      if (state == ST_RUN) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
        // A same-cycle mailbox hit takes priority over the timeout.
        if (!end_hit && cyc_limit) timeout <= 1'b1;
      end
      chk_req <= (state_nx == ST_CHECK);
      if (state_nx == ST_CHECK) begin
        chk_addr <= TEST_START + ADDR_W'(k_nx);
        gold_idx <= k_nx;
      end
      cmp_vld <= chk_req;
      cmp_idx <= gold_idx;
      if (cmp_vld && (rd_data != gold_data)) begin
        mis_valid <= 1'b1;
        mis_idx   <= cmp_idx;
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      end
      if (state == ST_DONE) begin
        done <= 1'b1;
        pass <= (err_cnt == '0) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_sim_end_checker.sv
// tb_sim_end_checker: randomized and directed runs of sim_end_checker against a
// scenario-level reference model (end cycle, timeout flag, mismatch list).
module tb_sim_end_checker;

  localparam int          D      = 4;
  localparam int          MAXC   = 300;
  localparam int          D_TO   = 1;
  localparam int          MAX_TO = 50;
  localparam logic [13:0] TS     = 14'h2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;

  logic        chk_req, mis_valid, done, pass, timeout;
  logic [13:0] chk_addr;
  logic [15:0] gold_idx, mis_idx, err_cnt;
  logic [31:0] rd_data, gold_data, cycle_cnt;

  logic        chk_req_to, mis_valid_to, done_to, pass_to, timeout_to;
  logic [13:0] chk_addr_to;
  logic [15:0] gold_idx_to, mis_idx_to, err_cnt_to;
  logic [31:0] rd_data_to, gold_data_to, cycle_cnt_to;

  always #5 clk = ~clk;

  sim_end_checker #(.CHECK_DEPTH(D), .MAX_CYCLES(MAXC)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .chk_req(chk_req), .chk_addr(chk_addr), .rd_data(rd_data),
    .gold_idx(gold_idx), .gold_data(gold_data),
    .mis_valid(mis_valid), .mis_idx(mis_idx), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .cycle_cnt(cycle_cnt)
  );

  sim_end_checker #(.CHECK_DEPTH(D_TO), .MAX_CYCLES(MAX_TO)) u_to (
    .clk(clk), .rst(rst), .wr_en(4'h0), .wr_addr(14'h0), .wr_data(32'h0),
    .chk_req(chk_req_to), .chk_addr(chk_addr_to), .rd_data(rd_data_to),
    .gold_idx(gold_idx_to), .gold_data(gold_data_to),
    .mis_valid(mis_valid_to), .mis_idx(mis_idx_to), .done(done_to), .pass(pass_to),
    .timeout(timeout_to), .err_cnt(err_cnt_to), .cycle_cnt(cycle_cnt_to)
  );

  // Harness memories: one-cycle read latency on both ports.
  logic [31:0] dm  [0:16383];
  logic [31:0] rom [0:15];
  always @(posedge clk) begin
    rd_data      <= dm[chk_addr];
    gold_data    <= rom[gold_idx[3:0]];
    rd_data_to   <= dm[chk_addr_to];
    gold_data_to <= rom[gold_idx_to[3:0]];
  end

  // Edges since reset release: after edge n this reads n+1.
  int pe;
  always @(posedge clk or posedge rst) begin
    if (rst) pe <= 0;
    else     pe <= pe + 1;
  end

  // Observation of sweep traffic, mismatch pulses and done timing.
  logic [13:0] q_addr [$];
  logic [15:0] q_gidx [$];
  logic [15:0] q_mis  [$];
  int          q_mis_pe [$];
  int          chk_rise, done_rise, to_chk_n, to_done_rise;
  logic [13:0] to_addr;
  always @(negedge clk) begin
    if (rst) begin
      q_addr.delete(); q_gidx.delete(); q_mis.delete(); q_mis_pe.delete();
      chk_rise = -1; done_rise = -1; to_chk_n = 0; to_done_rise = -1; to_addr = '0;
    end else begin
      if (chk_req) begin
        if (chk_rise < 0) chk_rise = pe;
        q_addr.push_back(chk_addr);
        q_gidx.push_back(gold_idx);
      end
      if (mis_valid) begin
        q_mis.push_back(mis_idx);
        q_mis_pe.push_back(pe);
      end
      if (done && done_rise < 0) done_rise = pe;
      if (chk_req_to) begin
        to_chk_n = to_chk_n + 1;
        to_addr  = chk_addr_to;
      end
      if (done_to && to_done_rise < 0) to_done_rise = pe;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Snooped write schedule, indexed by RUN cycle.
  logic [3:0]  ev_en   [0:511];
  logic [13:0] ev_addr [0:511];
  logic [31:0] ev_data [0:511];
  int          ev_last;

  task automatic clear_case();
    for (int i = 0; i < 512; i++) begin
      ev_en[i] = 4'h0; ev_addr[i] = '0; ev_data[i] = '0;
    end
    ev_last = 0;
  endtask

  task automatic add_ev(input int c, input logic [3:0] en, input logic [13:0] a, input logic [31:0] d);
    ev_en[c] = en; ev_addr[c] = a; ev_data[c] = d;
    if (c > ev_last) ev_last = c;
  endtask

  // Reference: first full mailbox store wins, otherwise the run ends at MAXC-1.
  function automatic int model_end(output bit to);
    for (int c = 0; c < MAXC; c++) begin
      if (ev_en[c] == 4'hF && ev_addr[c] == 14'h3fff && ev_data[c] == 32'hFFFF_FFFF) begin
        to = 1'b0;
        return c;
      end
    end
    to = 1'b1;
    return MAXC - 1;
  endfunction

  task automatic run_case(input string name, input bit rst_mid);
    int          n_end;
    bit          exp_to;
    int          exp_err;
    logic [15:0] exp_mis [$];
    int          lim;
    n_end   = model_end(exp_to);
    exp_err = 0;
    for (int k = 0; k < D; k++)
      if (dm[TS + k] != rom[k]) begin
        exp_err = exp_err + 1;
        exp_mis.push_back(16'(k));
      end

    rst = 1'b1; wr_en = 4'h0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= ev_last && c <= n_end; c++) begin
      wr_en = ev_en[c]; wr_addr = ev_addr[c]; wr_data = ev_data[c];
      @(posedge clk);
      @(negedge clk);
    end
    wr_en = 4'h0;

    if (rst_mid) begin
      lim = 0;
      while (pe < n_end + 3 && lim < 20) begin @(negedge clk); lim++; end
      check_val({name, ":mid_gidx"}, 32'(gold_idx), 32'd2);
      check_val({name, ":mid_mis"}, 32'(mis_valid), 32'd1);
      rst = 1'b1;
      #1;
      check_val({name, ":rst_flags"}, 32'({chk_req, mis_valid, done, pass, timeout}), 32'd0);
      check_val({name, ":rst_addr"}, 32'(chk_addr), 32'd0);
      check_val({name, ":rst_gidx"}, 32'(gold_idx), 32'd0);
      check_val({name, ":rst_misidx"}, 32'(mis_idx), 32'd0);
      check_val({name, ":rst_err"}, 32'(err_cnt), 32'd0);
      check_val({name, ":rst_cyc"}, cycle_cnt, 32'd0);
      return;
    end

    for (int w = 0; w < MAXC + 50 && !done; w++) @(negedge clk);
    check_val({name, ":done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
    check_val({name, ":chk_rise"}, chk_rise, n_end + 1);
    check_val({name, ":done_rise"}, done_rise, n_end + D + 3);
    check_val({name, ":chk_len"}, q_addr.size(), D);
    for (int k = 0; k < D && k < q_addr.size(); k++) begin
      check_val({name, ":chk_addr"}, 32'(q_addr[k]), 32'(TS + 14'(k)));
      check_val({name, ":gold_idx"}, 32'(q_gidx[k]), k);
    end
    check_val({name, ":mis_n"}, q_mis.size(), exp_mis.size());
    for (int i = 0; i < q_mis.size() && i < exp_mis.size(); i++) begin
      check_val({name, ":mis_idx"}, 32'(q_mis[i]), 32'(exp_mis[i]));
      check_val({name, ":mis_time"}, q_mis_pe[i], n_end + 3 + int'(exp_mis[i]));
    end
    check_val({name, ":err_cnt"}, 32'(err_cnt), exp_err);
    check_val({name, ":timeout"}, 32'(timeout), 32'(exp_to));
    check_val({name, ":pass"}, 32'(pass), 32'(exp_err == 0 && !exp_to));
    check_val({name, ":cycle_cnt"}, cycle_cnt, n_end + 1);

    // Writes after completion, even a valid end store, change nothing.
    wr_en = 4'hF; wr_addr = 14'h3fff; wr_data = 32'hFFFF_FFFF;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    wr_en = 4'h0;
    check_val({name, ":frz_cyc"}, cycle_cnt, n_end + 1);
    check_val({name, ":frz_done"}, 32'({done, chk_req}), 32'h2);
    check_val({name, ":frz_err"}, 32'(err_cnt), exp_err);

    // Second instance times out at MAX_TO with a one-word sweep.
    lim = 0;
    while (pe < MAX_TO + 10 && lim < 100) begin @(negedge clk); lim++; end
    check_val({name, ":to_timeout"}, 32'(timeout_to), 32'd1);
    check_val({name, ":to_cyc"}, cycle_cnt_to, MAX_TO);
    check_val({name, ":to_sweep"}, to_chk_n, D_TO);
    check_val({name, ":to_addr"}, 32'(to_addr), 32'(TS));
    check_val({name, ":to_done_rise"}, to_done_rise, MAX_TO + D_TO + 2);
    check_val({name, ":to_err"}, 32'(err_cnt_to), 32'(dm[TS] != rom[0]));
    check_val({name, ":to_pass"}, 32'(pass_to), 32'd0);
  endtask

  logic [3:0]  en_tab   [4];
  logic [13:0] addr_tab [3];

  initial begin
    wr_en = 4'h0; wr_addr = '0; wr_data = '0;
    en_tab   = '{4'h3, 4'hF, 4'h7, 4'h1};
    addr_tab = '{14'h3fff, 14'h3ffe, 14'h1234};
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < 16384; i++) dm[i] = '0;

    // Clean pass with false end stores before the real one.
    for (int k = 0; k < D; k++) begin dm[TS + k] = 32'(k + 1); rom[k] = 32'(k + 1); end
    clear_case();
    add_ev(10, 4'h3, 14'h3fff, 32'hFFFF_FFFF);
    add_ev(11, 4'hF, 14'h3fff, 32'h0);
    add_ev(12, 4'hF, 14'h3ffe, 32'hFFFF_FFFF);
    add_ev(100, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
    run_case("clean", 1'b0);

    // Single mismatching word.
    dm[TS + 2] = 32'hDEAD;
    clear_case();
    add_ev(60, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
    run_case("mismatch", 1'b0);
    dm[TS + 2] = 32'd3;

    // End store in the timeout cycle: the store wins.
    clear_case();
    add_ev(MAXC - 1, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
    run_case("conflict", 1'b0);

    // No end store: timeout, sweep still runs, pass stays low.
    clear_case();
    run_case("timeout", 1'b0);

    // Reset mid-sweep, then a clean run.
    dm[TS] = 32'h5;
    clear_case();
    add_ev(40, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
    run_case("rst_mid", 1'b1);
    dm[TS] = 32'd1;
    clear_case();
    add_ev(70, 4'hF, 14'h3fff, 32'hFFFF_FFFF);
    run_case("after_rst", 1'b0);

    // Randomized contents, stray mailbox writes and end cycle.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < D; k++) begin
        rom[k] = $urandom;
        dm[TS + k] = ($urandom_range(0, 2) == 0) ? (rom[k] ^ (32'h1 << $urandom_range(0, 31))) : rom[k];
      end
      clear_case();
      for (int j = 0; j < 4; j++)
        add_ev($urandom_range(0, MAXC - 1), en_tab[$urandom_range(0, 3)],
               addr_tab[$urandom_range(0, 2)],
               ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
      if ($urandom_range(0, 3) != 0)
        add_ev($urandom_range(0, MAXC - 1), 4'hF, 14'h3fff, 32'hFFFF_FFFF);
      run_case("random", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
